// File: rtl/mux_41_if.sv
// Bundle of the mux_41 select/data inputs and registered outputs.
// Optional sel_oh is present only when MUX_41_ONEHOT_EN is defined.
// The master modport drives the inputs and the slave modport is the mux itself.
interface mux_41_if #(
  parameter int DW = 1
);
  logic          in_vld;
  logic [2:0]    s;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] c;
  logic [DW-1:0] d;
  logic [DW-1:0] e;
  logic [DW-1:0] f;
  logic [DW-1:0] g;
  logic [DW-1:0] h;
  logic [DW-1:0] y;
  logic          y_vld;
  logic [2:0]    sel_q;
`ifdef MUX_41_ONEHOT_EN
  logic [7:0]    sel_oh;

  modport master (
    output in_vld, s, a, b, c, d, e, f, g, h,
    input  y, y_vld, sel_q, sel_oh
  );
  modport slave (
    input  in_vld, s, a, b, c, d, e, f, g, h,
    output y, y_vld, sel_q, sel_oh
  );
`else
  modport master (
    output in_vld, s, a, b, c, d, e, f, g, h,
    input  y, y_vld, sel_q
  );
  modport slave (
    input  in_vld, s, a, b, c, d, e, f, g, h,
    output y, y_vld, sel_q
  );
`endif
endinterface

// File: rtl/mux_41.sv
// Registered 8-to-1 reversed-index mux (s=0 -> h ... s=7 -> a) with a valid qualifier.
// Latency 1 cycle; y/sel_q hold when in_vld is low, y_vld pulses once per capture.
// No backpressure: every in_vld is accepted. Optional one-hot select copy via MUX_41_ONEHOT_EN.
module mux_41 #(
  parameter int DW = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_41_if.slave  bus
);

  logic [DW-1:0] sel_dat;

  // Reversed-index selection: input index is 7 - s.
  always_comb begin
    sel_dat = '0;
    case (bus.s)
      3'd0:    sel_dat = bus.h;
      3'd1:    sel_dat = bus.g;
      3'd2:    sel_dat = bus.f;
      3'd3:    sel_dat = bus.e;
      3'd4:    sel_dat = bus.d;
      3'd5:    sel_dat = bus.c;
      3'd6:    sel_dat = bus.b;
      3'd7:    sel_dat = bus.a;
      default: sel_dat = '0;
    endcase
  end

  // Capture data and select on in_vld; valid is a one-cycle echo of in_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y     <= '0;
      bus.sel_q <= 3'd0;
      bus.y_vld <= 1'b0;
    end else begin
      bus.y_vld <= bus.in_vld;
      if (bus.in_vld) begin
        bus.y     <= sel_dat;
        bus.sel_q <= bus.s;
      end
    end
  end

`ifdef MUX_41_ONEHOT_EN
  logic [7:0] sel_oh_nxt;

  // One-hot bit position matches the selected input index (a = bit 0).
  always_comb begin
    sel_oh_nxt = 8'h00;
    sel_oh_nxt[3'd7 - bus.s] = 1'b1;
  end

  // One-hot select copy, captured alongside y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sel_oh <= 8'h00;
    end else if (bus.in_vld) begin
      bus.sel_oh <= sel_oh_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mux_41.sv
// Self-checking bench for mux_41: DW=1 and DW=4 instances driven in lockstep.
// Expected captures are queued at drive time and popped when the outputs appear.
module tb_mux_41;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mux_41_if #(.DW(1)) if1 ();
  mux_41_if #(.DW(4)) if4 ();

  mux_41 #(.DW(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mux_41 #(.DW(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic       y1;
    logic [3:0] y4;
    logic [2:0] sel;
    logic [7:0] oh;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] v1;
  logic [3:0] v4 [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_y1"}, 32'(if1.y), 32'd0);
    chk({tag, "_y4"}, 32'(if4.y), 32'd0);
    chk({tag, "_vld1"}, 32'(if1.y_vld), 32'd0);
    chk({tag, "_vld4"}, 32'(if4.y_vld), 32'd0);
    chk({tag, "_sel1"}, 32'(if1.sel_q), 32'd0);
    chk({tag, "_sel4"}, 32'(if4.sel_q), 32'd0);
`ifdef MUX_41_ONEHOT_EN
    chk({tag, "_oh"}, 32'(if1.sel_oh), 32'd0);
`endif
  endtask

  task automatic apply_inputs(input logic vld, input logic [2:0] sel);
    if1.in_vld = vld; if4.in_vld = vld;
    if1.s = sel;      if4.s = sel;
    if1.a = v1[0]; if1.b = v1[1]; if1.c = v1[2]; if1.d = v1[3];
    if1.e = v1[4]; if1.f = v1[5]; if1.g = v1[6]; if1.h = v1[7];
    if4.a = v4[0]; if4.b = v4[1]; if4.c = v4[2]; if4.d = v4[3];
    if4.e = v4[4]; if4.f = v4[5]; if4.g = v4[6]; if4.h = v4[7];
  endtask

  // Drive one cycle, clock it, then check the registered outputs.
  task automatic step(input string tag, input logic vld, input logic [2:0] sel);
    exp_t x;
    int   idx;
    apply_inputs(vld, sel);
    if (vld) begin
      idx   = 7 - int'(sel);
      x.y1  = v1[idx];
      x.y4  = v4[idx];
      x.sel = sel;
      x.oh  = 8'h00;
      x.oh[idx] = 1'b1;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    chk({tag, "_vld1"}, 32'(if1.y_vld), 32'(vld));
    chk({tag, "_vld4"}, 32'(if4.y_vld), 32'(vld));
    if (vld) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
        last = exp_q.pop_front();
      end
    end
    chk({tag, "_y1"}, 32'(if1.y), 32'(last.y1));
    chk({tag, "_y4"}, 32'(if4.y), 32'(last.y4));
    chk({tag, "_sel1"}, 32'(if1.sel_q), 32'(last.sel));
    chk({tag, "_sel4"}, 32'(if4.sel_q), 32'(last.sel));
`ifdef MUX_41_ONEHOT_EN
    chk({tag, "_oh"}, 32'(if1.sel_oh), 32'(last.oh));
`endif
  endtask

  task automatic clear_last();
    last.y1 = 1'b0; last.y4 = 4'h0; last.sel = 3'd0; last.oh = 8'h00;
    exp_q.delete();
  endtask

  initial begin
    v1 = 8'h00;
    for (int i = 0; i < 8; i++) v4[i] = 4'h0;
    clear_last();
    apply_inputs(1'b0, 3'd0);

    // Reset state, then release away from the clock edge.
    #3;
    check_outputs_zero("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Walking one: only the selected input high.
    for (int k = 0; k < 8; k++) begin
      v1 = 8'h00;
      for (int i = 0; i < 8; i++) v4[i] = 4'h0;
      v1[7 - k] = 1'b1;
      v4[7 - k] = 4'hF;
      step($sformatf("walk%0d", k), 1'b1, 3'(k));
    end

    // Inverse isolation: only the selected input low.
    for (int k = 0; k < 8; k++) begin
      v1 = 8'hFF;
      for (int i = 0; i < 8; i++) v4[i] = 4'hF;
      v1[7 - k] = 1'b0;
      v4[7 - k] = 4'h0;
      step($sformatf("inv%0d", k), 1'b1, 3'(k));
    end

    // Hold: capture s=2 with f high, then toggle everything with in_vld low.
    v1 = 8'h20;
    for (int i = 0; i < 8; i++) v4[i] = 4'h0;
    v4[5] = 4'hA;
    step("hold_cap", 1'b1, 3'd2);
    for (int k = 0; k < 3; k++) begin
      v1 = 8'($urandom);
      for (int i = 0; i < 8; i++) v4[i] = 4'($urandom);
      step($sformatf("hold%0d", k), 1'b0, 3'($urandom_range(0, 7)));
    end

    // Back-to-back captures with distinct per-input values.
    for (int i = 0; i < 8; i++) v4[i] = 4'(i + 1);
    v1 = 8'b0101_1010;
    step("b2b0", 1'b1, 3'd0);
    step("b2b1", 1'b1, 3'd7);
    step("b2b2", 1'b1, 3'd3);

    // Random traffic with a mix of valid and idle cycles.
    for (int k = 0; k < 40; k++) begin
      v1 = 8'($urandom);
      for (int i = 0; i < 8; i++) v4[i] = 4'($urandom);
      step($sformatf("rnd%0d", k), 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
    end

    // Mid-cycle asynchronous reset with y=1 and a pending capture discarded.
    v1 = 8'h04;
    for (int i = 0; i < 8; i++) v4[i] = 4'h9;
    step("pre_rst", 1'b1, 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    v1 = 8'hFF;
    apply_inputs(1'b1, 3'd0);
    @(posedge clk);
    #1;
    check_outputs_zero("rst_hold");
    @(negedge clk);
    clear_last();
    apply_inputs(1'b0, 3'd0);
    rst_n = 1'b1;

    // Capture after reset release.
    v1 = 8'h80;
    for (int i = 0; i < 8; i++) v4[i] = 4'(i + 1);
    step("post_rst", 1'b1, 3'd0);
    step("post_idle", 1'b0, 3'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_41.md
Name: mux_41

Overview:
- Registered 8-to-1 multiplexer with a valid qualifier.
- Selects one of eight data inputs (a..h) using a 3-bit select and presents the result one clock later.
- Used as a small steering stage in datapaths needing a clean, glitch-free registered select output.

Parameters:
- DW, 1, data width of each input and of y.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_vld  input  1  when high, s and a..h are sampled this cycle.
- s  input  3  select code.
- a  input  DW  data input, index 0.
- b  input  DW  data input, index 1.
- c  input  DW  data input, index 2.
- d  input  DW  data input, index 3.
- e  input  DW  data input, index 4.
- f  input  DW  data input, index 5.
- g  input  DW  data input, index 6.
- h  input  DW  data input, index 7.
- y  output  DW  registered selected data.
- y_vld  output  1  high for exactly the cycle after each cycle with in_vld high.
- sel_q  output  3  registered copy of the s value that produced y.

Behaviour:
- Select mapping is reversed-index: s=000→h, 001→g, 010→f, 011→e, 100→d, 101→c, 110→b, 111→a. Equivalently, input index = 7 − s.
- Latency is 1 cycle.
  - On a rising clk with in_vld=1: y ← selected input, sel_q ← s, y_vld ← 1.
  - On a rising clk with in_vld=0: y and sel_q hold their previous values; y_vld ← 0.
- No combinational path from any input to any output.
- Reset (rst_n=0, asynchronous assert): y=0, sel_q=000, y_vld=0 immediately, regardless of clk.
  - Reset release is synchronized by the integrator; the first capture happens on the first rising edge with rst_n=1 and in_vld=1.
- Reset mid-operation clears all outputs immediately; any pending capture is discarded.
- Non-selected inputs have no effect on y.
- s and data may change every cycle; back-to-back in_vld produces back-to-back y_vld.
- X or Z on s while in_vld=1: y is undefined for that capture. Benches drive s to known values only.
- All DW bits are selected together; there is no per-bit selection.

Optional Feature:
- Macro: MUX_41_ONEHOT_EN.
- When defined:
  - Adds output sel_oh, 8 bits, registered alongside y.
  - Bit (7 − s) is set, i.e. bit index equals the selected input index (a=bit0 … h=bit7).
  - sel_oh updates only on in_vld captures and holds otherwise.
  - Resets to 8'h00.
- When undefined: the sel_oh port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with y=1 → y=0, y_vld=0, sel_q=000 immediately, without waiting for a clock edge.
- Walking one, DW=1: for k=0..7, in_vld=1, s=k, only the input at index 7−k high (s=000 with h=1; s=001 with g=1; … s=111 with a=1) → y=1 and y_vld=1 one cycle later, sel_q=k.
- Inverse isolation: s=000, h=0, a..g all 1 → y=0. Repeat for all eight selects with only the selected input low → y=0 each time.
- Hold: capture with s=010, f=1, then in_vld=0 while s and inputs toggle for 3 cycles → y stays 1, sel_q stays 010, y_vld=0 on all three cycles.
- Back-to-back, DW=4: a=4'h1 … h=4'h8, in_vld=1 on consecutive cycles with s=000, 111, 011 → y=8, 1, 5 on the following consecutive cycles, y_vld high throughout.
- MUX_41_ONEHOT_EN defined: s=101 captured → sel_oh=8'b0000_0100. After reset → sel_oh=8'h00.
